ptw_responder: RTL

PTW_RESPONDER -- requirements
Module: ptw_responder

---
 rtl/ptw_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ptw_responder.sv
// ptw_responder
//   Minimal page-table-walk responder shared by an instruction TLB and a
//   data TLB. One walk is in flight at a time. Each walk reads a single PTE
//   at PTBR + vpn*4, decodes it, and returns error/ppn to the client that
//   asked. When both clients request at once, the one not served last wins.
//
// Parameters
//   PTBR    : page-table base byte address
//   TIMEOUT : MWAIT cycle limit (only with PTW_RESPONDER_TIMEOUT_EN)
//
// Optional feature
//   PTW_RESPONDER_TIMEOUT_EN : when defined, a walk that waits TIMEOUT cycles
//   for PTE data completes with error = 1 and ppn = 0. Otherwise MWAIT waits
//   indefinitely.
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   io_imem_ptw_req_*            : instruction-TLB request (valid/ready/vpn)
//   io_dmem_ptw_req_*            : data-TLB request (valid/ready/vpn)
//   io_imem_ptw_resp_*           : instruction-TLB response (valid/error/ppn)
//   io_dmem_ptw_resp_*           : data-TLB response (valid/error/ppn)
//   io_mem_req_*                 : PTE read request (valid/ready/addr)
//   io_mem_resp_*                : PTE read data (valid/data)
module ptw_responder #(
  parameter logic [31:0] PTBR    = 32'h00001000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_imem_ptw_req_valid,
  output logic        io_imem_ptw_req_ready,
  input  logic [19:0] io_imem_ptw_req_bits_vpn,
  input  logic        io_dmem_ptw_req_valid,
  output logic        io_dmem_ptw_req_ready,
  input  logic [19:0] io_dmem_ptw_req_bits_vpn,
  output logic        io_imem_ptw_resp_valid,
  output logic        io_imem_ptw_resp_bits_error,
  output logic [31:0] io_imem_ptw_resp_bits_ppn,
  output logic        io_dmem_ptw_resp_valid,
  output logic        io_dmem_ptw_resp_bits_error,
  output logic [31:0] io_dmem_ptw_resp_bits_ppn,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_bits_addr,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_bits_data
);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_e;

  localparam logic CLIENT_IMEM = 1'b0;
  localparam logic CLIENT_DMEM = 1'b1;

  state_e      state_q, state_d;
  logic        lastGrant_q, lastGrant_d;
  logic        client_q, client_d;
  logic [31:0] addr_q, addr_d;
  logic        imemError_q, imemError_d;
  logic [31:0] imemPpn_q, imemPpn_d;
  logic        dmemError_q, dmemError_d;
  logic [31:0] dmemPpn_q, dmemPpn_d;

  logic        grantImem;
  logic        grantDmem;
  logic        pteError;
  logic [31:0] ptePpn;
  logic        timedOut;
  logic        unusedPteBits;

  // Round-robin arbitration: a lone requester always wins; on a tie the
  // client that was not served last goes first.
  always_comb begin
    grantImem = 1'b0;
    grantDmem = 1'b0;
    if (io_imem_ptw_req_valid && io_dmem_ptw_req_valid) begin
      grantImem = (lastGrant_q == CLIENT_DMEM);
      grantDmem = (lastGrant_q == CLIENT_IMEM);
    end else begin
      grantImem = io_imem_ptw_req_valid;
      grantDmem = io_dmem_ptw_req_valid;
    end
  end

  // A PTE is usable only when its valid bit (bit 0) is set; the ppn lives in
  // the upper 22 bits. Permission bits are not interpreted here.
  assign pteError      = ~io_mem_resp_bits_data[0];
  assign ptePpn        = pteError ? 32'h0 : {10'b0, io_mem_resp_bits_data[31:10]};
  assign unusedPteBits = ^io_mem_resp_bits_data[9:1];

`ifdef PTW_RESPONDER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [31:0] waitCount_q, waitCount_d;

  // The counter sits at zero outside MWAIT, so it is naturally cleared on
  // entry. Comparing against TIMEOUT-1 means the walk gives up in the cycle
  // where the count would reach TIMEOUT, so RESP comes TIMEOUT cycles after
  // MWAIT was entered.
  always_comb begin
    waitCount_d = (state_q == MWAIT) ? waitCount_q + 32'd1 : 32'd0;
    timedOut    = (state_q == MWAIT) && (waitCount_q == TIMEOUT_LAST);
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCount_q <= 32'd0;
    end else begin
      waitCount_q <= waitCount_d;
    end
  end
`else
  logic unusedTimeout;

  assign timedOut      = 1'b0;
  assign unusedTimeout = (TIMEOUT == 0);
`endif

  // Walk FSM: next state, captured request, decoded response and all
  // handshake outputs. Reset forces every valid/ready output low even
  // before the state register has been cleared.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    client_d    = client_q;
    addr_d      = addr_q;
    imemError_d = imemError_q;
    imemPpn_d   = imemPpn_q;
    dmemError_d = dmemError_q;
    dmemPpn_d   = dmemPpn_q;

    io_imem_ptw_req_ready  = 1'b0;
    io_dmem_ptw_req_ready  = 1'b0;
    io_imem_ptw_resp_valid = 1'b0;
    io_dmem_ptw_resp_valid = 1'b0;
    io_mem_req_valid       = 1'b0;

    unique case (state_q)
      IDLE: begin
        io_imem_ptw_req_ready = grantImem;
        io_dmem_ptw_req_ready = grantDmem;
        if (grantImem || grantDmem) begin
          client_d    = grantDmem;
          lastGrant_d = grantDmem;
          addr_d      = PTBR + {10'b0,
                                (grantDmem ? io_dmem_ptw_req_bits_vpn
                                           : io_imem_ptw_req_bits_vpn),
                                2'b00};
          state_d     = MREQ;
        end
      end
      MREQ: begin
        io_mem_req_valid = 1'b1;
        if (io_mem_req_ready) begin
          state_d = MWAIT;
        end
      end
      MWAIT: begin
        if (io_mem_resp_valid || timedOut) begin
          if (client_q == CLIENT_DMEM) begin
            dmemError_d = io_mem_resp_valid ? pteError : 1'b1;
            dmemPpn_d   = io_mem_resp_valid ? ptePpn : 32'h0;
          end else begin
            imemError_d = io_mem_resp_valid ? pteError : 1'b1;
            imemPpn_d   = io_mem_resp_valid ? ptePpn : 32'h0;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        io_imem_ptw_resp_valid = (client_q == CLIENT_IMEM);
        io_dmem_ptw_resp_valid = (client_q == CLIENT_DMEM);
        state_d                = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      io_imem_ptw_req_ready  = 1'b0;
      io_dmem_ptw_req_ready  = 1'b0;
      io_imem_ptw_resp_valid = 1'b0;
      io_dmem_ptw_resp_valid = 1'b0;
      io_mem_req_valid       = 1'b0;
    end
  end

  // State and datapath registers. last grant resets to dmem so that the
  // first tie after reset goes to imem.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= CLIENT_DMEM;
      client_q    <= CLIENT_IMEM;
      addr_q      <= 32'h0;
      imemError_q <= 1'b0;
      imemPpn_q   <= 32'h0;
      dmemError_q <= 1'b0;
      dmemPpn_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      client_q    <= client_d;
      addr_q      <= addr_d;
      imemError_q <= imemError_d;
      imemPpn_q   <= imemPpn_d;
      dmemError_q <= dmemError_d;
      dmemPpn_q   <= dmemPpn_d;
    end
  end

  assign io_mem_req_bits_addr        = addr_q;
  assign io_imem_ptw_resp_bits_error = imemError_q;
  assign io_imem_ptw_resp_bits_ppn   = imemPpn_q;
  assign io_dmem_ptw_resp_bits_error = dmemError_q;
  assign io_dmem_ptw_resp_bits_ppn   = dmemPpn_q;

endmodule
